cpu_loader: RTL and testbench
=============================

CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 4: external-port address increment per word.
REQ-002 SHALL have parameter IMEM_WORDS, default 512: instruction memory capacity in words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a load/run/dump session; sampled only in IDLE.
REQ-006 SHALL have ports run_cycles and dump_words, input, 16 bits each: both latched on an accepted start.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, 32), in_last (input, 1) and in_ready (output, 1): program word stream.
REQ-008 SHALL have ports out_valid (output, 1), out_data (output, 32) and out_ready (input, 1): data-memory dump stream.
REQ-009 SHALL have ports busy, done and load_err, output, 1 bit each: session status.
REQ-010 SHALL have port cpu_enable, output, 1 bit: drives the CPU enable.
REQ-011 SHALL have ports addr_ext (output, 32), wen_ext (output, 1), ren_ext (output, 1) and wdata_ext (output, 32): instruction memory external port.
REQ-012 SHALL have ports addr_ext_2 (output, 32), wen_ext_2 (output, 1), ren_ext_2 (output, 1), wdata_ext_2 (output, 32) and rdata_ext_2 (input, 32): data memory external port.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE.
REQ-014 IDLE: on start=1, SHALL latch run_cycles and dump_words, clear the word counter and load_err, and go to LOAD next cycle.
REQ-015 LOAD: in_ready SHALL be 1; a word is accepted in a cycle with in_valid & in_ready.
REQ-016 On each accepted word, SHALL drive in that same cycle wen_ext=1, wdata_ext=in_data, addr_ext=word_count*ADDR_STEP; word_count then increments.
REQ-017 Accepting a word with in_last=1 SHALL move LOAD to RUN.
REQ-018 An accepted word when word_count >= IMEM_WORDS SHALL NOT be written (wen_ext=0); load_err SHALL be set sticky, and LOAD continues until in_last.
REQ-019 RUN: cpu_enable SHALL be 1 for exactly run_cycles consecutive cycles, then the FSM goes to DUMP_RD.
REQ-020 run_cycles=0 SHALL skip RUN with zero enable cycles.
REQ-021 dump_words=0 SHALL go from RUN directly to DONE.
REQ-022 DUMP_RD: SHALL drive ren_ext_2=1 and addr_ext_2=dump_idx*ADDR_STEP for one cycle, then go to DUMP_WAIT.
REQ-023 DUMP_WAIT: SHALL capture rdata_ext_2 into out_data (one-cycle synchronous read latency), then go to DUMP_OUT.
REQ-024 DUMP_OUT: out_valid SHALL be 1 and out_data held stable until out_ready=1.
REQ-025 On the DUMP_OUT handshake, dump_idx SHALL increment; if it reaches dump_words the FSM goes to DONE, otherwise to DUMP_RD.
REQ-026 DONE: done SHALL pulse 1 for one cycle, then the FSM returns to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start asserted outside IDLE SHALL be ignored.
REQ-029 ren_ext, wen_ext_2 and wdata_ext_2 SHALL be constant 0.
REQ-030 addr_ext and addr_ext_2 SHALL be 0 whenever the respective enable is 0.
REQ-031 wdata_ext SHALL be 0 whenever wen_ext is 0.
REQ-032 Counters SHALL be 16 bits; the address product SHALL be zero-extended to 32 bits.
REQ-033 cpu_enable SHALL be 0 in every state other than RUN.

Reset
REQ-034 While arst_n=0, the FSM SHALL be IDLE and all outputs and counters 0, including in_ready, out_valid, cpu_enable, done and load_err.
REQ-035 Reset asserted mid-session (LOAD, RUN or DUMP) SHALL abort immediately, with cpu_enable and all memory enables low asynchronously.
REQ-036 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-037 Load: start, then 3 words 0x20010005, 0x20020007, 0x00221820 (last) -> wen_ext pulses at addr 0, 4, 8 with matching wdata; then RUN.
REQ-038 Run/dump: run_cycles=10, dump_words=2, rdata_ext_2 returns 0xA then 0xB -> cpu_enable high exactly 10 cycles; out_data 0xA then 0xB; done pulses once.
REQ-039 Backpressure: out_ready held 0 for 5 cycles in DUMP_OUT -> out_valid stays 1, out_data stable, no further ren_ext_2 pulse.
REQ-040 Overflow: IMEM_WORDS=4, send 6 words -> only addrs 0..12 written; load_err=1; session completes.
REQ-041 Zero counts: run_cycles=0, dump_words=0 -> no cpu_enable cycle, no ren_ext_2; done pulses 2 cycles after the last load word is accepted.
REQ-042 Reset in RUN at cycle 3 -> cpu_enable drops without a clock edge; busy=0; a new start restarts with word_count=0.

Source files
------------

// File: rtl/cpu_loader.sv
// Program loader and sequencer for a small CPU: streams words into instruction memory,
// lets the CPU run for a fixed number of cycles, then streams data memory back out.
module cpu_loader #(
    parameter int ADDR_STEP  = 4,
    parameter int IMEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [15:0] run_cycles,
    input  logic [15:0] dump_words,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        load_err,
    output logic        cpu_enable,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    input  logic [31:0] rdata_ext_2
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
    } state_t;

    localparam logic [31:0] STEP  = 32'(ADDR_STEP);
    localparam logic [31:0] LIMIT = 32'(IMEM_WORDS);

    state_t      state_reg, state_next;
    logic [15:0] run_cycles_reg, dump_words_reg;
    logic [15:0] word_count_reg, run_count_reg, dump_idx_reg;
    logic [31:0] out_data_reg;
    logic        load_err_reg;

    logic accept, in_range, run_last, dump_last;

    assign accept    = (state_reg == LOAD) && in_valid;
    assign in_range  = {16'd0, word_count_reg} < LIMIT;
    assign run_last  = (run_cycles_reg == 16'd0) || (run_count_reg == run_cycles_reg - 16'd1);
    assign dump_last = (dump_idx_reg + 16'd1) == dump_words_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (start) state_next = LOAD;
            LOAD:      if (accept && in_last) state_next = RUN;
            RUN:       if (run_last) state_next = (dump_words_reg == 16'd0) ? DONE : DUMP_RD;
            DUMP_RD:   state_next = DUMP_WAIT;
            DUMP_WAIT: state_next = DUMP_OUT;
            DUMP_OUT:  if (out_ready) state_next = dump_last ? DONE : DUMP_RD;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            run_cycles_reg <= 16'd0;
            dump_words_reg <= 16'd0;
            word_count_reg <= 16'd0;
            run_count_reg  <= 16'd0;
            dump_idx_reg   <= 16'd0;
            out_data_reg   <= 32'd0;
            load_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        run_cycles_reg <= run_cycles;
                        dump_words_reg <= dump_words;
                        word_count_reg <= 16'd0;
                        run_count_reg  <= 16'd0;
                        dump_idx_reg   <= 16'd0;
                        load_err_reg   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (!in_range) load_err_reg <= 1'b1;
                        // Saturate so an oversized stream can never wrap back into range.
                        if (word_count_reg != 16'hFFFF) word_count_reg <= word_count_reg + 16'd1;
                    end
                end
                RUN:       run_count_reg <= run_count_reg + 16'd1;
                DUMP_WAIT: out_data_reg <= rdata_ext_2;
                DUMP_OUT:  if (out_ready) dump_idx_reg <= dump_idx_reg + 16'd1;
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state register so reset clears them without a clock.
    always_comb begin
        in_ready    = (state_reg == LOAD);
        wen_ext     = accept && in_range;
        addr_ext    = wen_ext ? ({16'd0, word_count_reg} * STEP) : 32'd0;
        wdata_ext   = wen_ext ? in_data : 32'd0;
        ren_ext     = 1'b0;
        cpu_enable  = (state_reg == RUN) && (run_cycles_reg != 16'd0);
        ren_ext_2   = (state_reg == DUMP_RD);
        addr_ext_2  = ren_ext_2 ? ({16'd0, dump_idx_reg} * STEP) : 32'd0;
        wen_ext_2   = 1'b0;
        wdata_ext_2 = 32'd0;
        out_valid   = (state_reg == DUMP_OUT);
        out_data    = out_data_reg;
        busy        = (state_reg != IDLE);
        done        = (state_reg == DONE);
        load_err    = load_err_reg;
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: table of sessions plus an asynchronous-reset abort sequence.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] run_cycles = 16'd0;
    logic [15:0] dump_words = 16'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy, done, load_err, cpu_enable;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext_2 = 32'd0;

    cpu_loader #(.ADDR_STEP(4), .IMEM_WORDS(4)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .run_cycles(run_cycles), .dump_words(dump_words),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .load_err(load_err), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dval(input logic [31:0] i);
        if (i == 0) return 32'h0000_000A;
        if (i == 1) return 32'h0000_000B;
        return 32'h0000_0100 + i;
    endfunction

    function automatic logic [31:0] word(input int idx, input int i);
        logic [31:0] spec_words [3];
        spec_words[0] = 32'h2001_0005;
        spec_words[1] = 32'h2002_0007;
        spec_words[2] = 32'h0022_1820;
        if (idx == 0 && i < 3) return spec_words[i];
        return 32'h1000_0000 | (32'(idx) << 8) | 32'(i);
    endfunction

    // Monitor state, sampled on the falling edge.
    logic [31:0] wq_addr[$], wq_data[$], rq_addr[$], oq[$];
    int en_cnt, en_first, en_last, done_cnt, done_cyc, last_acc_cyc;
    logic        pend_ren = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic        prev_ov = 1'b0, prev_hs = 1'b0;
    logic [31:0] prev_od = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pend_ren) rdata_ext_2 <= dval(pend_addr >> 2);
    end

    always @(negedge clk) begin
        if (arst_n) begin
            if (wen_ext) begin
                wq_addr.push_back(addr_ext);
                wq_data.push_back(wdata_ext);
            end
            if (!wen_ext && (addr_ext != 0 || wdata_ext != 0))
                chk("imem_idle_zero", addr_ext | wdata_ext, 32'd0);
            if (ren_ext || wen_ext_2 || wdata_ext_2 != 0)
                chk("const_zero", {30'd0, ren_ext, wen_ext_2} | wdata_ext_2, 32'd0);
            if (in_valid && in_ready && in_last) last_acc_cyc = cyc;
            if (cpu_enable) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                en_cnt++;
            end
            pend_ren  = ren_ext_2;
            pend_addr = addr_ext_2;
            if (ren_ext_2) rq_addr.push_back(addr_ext_2);
            if (out_valid && prev_ov && !prev_hs) begin
                chk("out_data_stable", out_data, prev_od);
                chk("no_ren_in_stall", {31'd0, ren_ext_2}, 32'd0);
            end
            if (out_valid && out_ready) oq.push_back(out_data);
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
            prev_od = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            pend_ren = 1'b0;
            prev_ov  = 1'b0;
        end
    end

    task automatic clear_mon();
        wq_addr.delete(); wq_data.delete(); rq_addr.delete(); oq.delete();
        en_cnt = 0; en_first = -1; en_last = -1;
        done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
    endtask

    task automatic load_words(input int idx, input int nw, input int rc, input int dw);
        @(posedge clk); #1;
        start = 1'b1; run_cycles = 16'(rc); dump_words = 16'(dw);
        @(posedge clk); #1;
        start = 1'b0; run_cycles = 16'd77; dump_words = 16'd9;
        chk("busy_in_load", {31'd0, busy}, 32'd1);
        for (int i = 0; i < nw; i++) begin
            in_valid = 1'b1;
            in_data  = word(idx, i);
            in_last  = (i == nw - 1);
            start    = (i == 0);     // must be ignored outside IDLE
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic do_session(input int idx, input int nw, input int rc, input int dw,
                              input int stall, input bit exp_err);
        int t, stall_cnt, nwr, lat;
        clear_mon();
        load_words(idx, nw, rc, dw);
        t = 0; stall_cnt = 0;
        while (done_cnt == 0 && t < 500) begin
            if (out_valid && stall_cnt < stall) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) stall_cnt = 0;
            end
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0;
        if (done_cnt == 0) chk($sformatf("s%0d_done_timeout", idx), 32'd0, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        nwr = (nw < 4) ? nw : 4;
        chk($sformatf("s%0d_nwrites", idx), wq_addr.size(), nwr);
        for (int i = 0; i < nwr && i < wq_addr.size(); i++) begin
            chk($sformatf("s%0d_waddr%0d", idx, i), wq_addr[i], 32'(4 * i));
            chk($sformatf("s%0d_wdata%0d", idx, i), wq_data[i], word(idx, i));
        end
        chk($sformatf("s%0d_en_cycles", idx), en_cnt, rc);
        if (rc > 0) chk($sformatf("s%0d_en_contig", idx), en_last - en_first + 1, rc);
        chk($sformatf("s%0d_nreads", idx), rq_addr.size(), dw);
        for (int i = 0; i < dw && i < rq_addr.size(); i++)
            chk($sformatf("s%0d_raddr%0d", idx, i), rq_addr[i], 32'(4 * i));
        chk($sformatf("s%0d_nout", idx), oq.size(), dw);
        for (int i = 0; i < dw && i < oq.size(); i++)
            chk($sformatf("s%0d_out%0d", idx, i), oq[i], dval(i));
        chk($sformatf("s%0d_done_cnt", idx), done_cnt, 1);
        lat = ((rc > 0) ? rc : 1) + dw * (3 + stall) + 1;
        chk($sformatf("s%0d_done_lat", idx), done_cyc - last_acc_cyc, lat);
        chk($sformatf("s%0d_load_err", idx), {31'd0, load_err}, {31'd0, exp_err});
        chk($sformatf("s%0d_busy_after", idx), {31'd0, busy}, 32'd0);
        $display("session %0d: words=%0d run=%0d dump=%0d stall=%0d writes=%0d en=%0d outs=%0d",
                 idx, nw, rc, dw, stall, wq_addr.size(), en_cnt, oq.size());
    endtask

    typedef struct {
        int nw;
        int rc;
        int dw;
        int stall;
        bit exp_err;
    } sess_t;

    sess_t tbl [5];

    initial begin
        int t;
        tbl[0] = '{nw: 3, rc: 10, dw: 2, stall: 0, exp_err: 1'b0};
        tbl[1] = '{nw: 3, rc: 2,  dw: 1, stall: 5, exp_err: 1'b0};
        tbl[2] = '{nw: 6, rc: 1,  dw: 1, stall: 0, exp_err: 1'b1};
        tbl[3] = '{nw: 2, rc: 0,  dw: 0, stall: 0, exp_err: 1'b0};
        tbl[4] = '{nw: 4, rc: 3,  dw: 3, stall: 1, exp_err: 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_mem_en", {28'd0, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 32'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int s = 0; s < 5; s++)
            do_session(s, tbl[s].nw, tbl[s].rc, tbl[s].dw, tbl[s].stall, tbl[s].exp_err);

        // Abort in RUN on the third enable cycle, mid clock period.
        clear_mon();
        load_words(5, 2, 20, 1);
        t = 0;
        while (en_cnt < 3 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (en_cnt < 3) chk("abort_reach_run", en_cnt, 3);
        #2;
        chk("abort_pre_enable", {31'd0, cpu_enable}, 32'd1);
        arst_n = 1'b0;
        #1;
        chk("abort_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        $display("abort: reset asserted after %0d enable cycles", en_cnt);
        @(posedge clk); #1;
        arst_n = 1'b1;
        do_session(6, 2, 1, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
